// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state set, bit-timing
// derivation and protocol byte constants used by the command path.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } uart_state_t;

   localparam logic [7:0] LINE_TERM  = 8'h0A;
   localparam logic [7:0] RESP_START = 8'h3E;

   // Clocks per serial bit, truncated.
   function automatic int unsigned calc_clks_per_bit(input int unsigned clock_rate,
                                                     input int unsigned baud_rate);
      return clock_rate / baud_rate;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Reset value is a parameter so idle-high lines come out of reset inactive.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_Clock,
   input  logic i_Rst_n,
   input  logic i_D,
   output logic o_Q
);

   logic meta;

   // Double-register the input; both stages preset to RESET_VAL.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         meta <= RESET_VAL;
         o_Q  <= RESET_VAL;
      end else begin
         meta <= i_D;
         o_Q  <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with input synchroniser, mid-bit sampling, start-bit
// glitch rejection, framing-error strobe and break (held-low) recovery.
module uart_rx_oversampled
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_RATE = 50000000,
   parameter int unsigned BAUD_RATE  = 115200
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_RX_Serial,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   output logic       o_Framing_Err,
   output logic       o_Busy
);

   localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLOCK_RATE, BAUD_RATE);
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_cpb_check
         $error("uart_rx_oversampled: CLKS_PER_BIT must be at least 4");
      end
   endgenerate

   uart_state_t      state;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             rx_s;

   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_sync_rx (
      .i_Clock (i_Clock),
      .i_Rst_n (i_Rst_n),
      .i_D     (i_RX_Serial),
      .o_Q     (rx_s)
   );

   assign o_Busy = (state != ST_IDLE);

   // Receive FSM: start qualification, data shift-in, stop check, break wait.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state         <= ST_IDLE;
         clk_cnt       <= '0;
         bit_idx       <= '0;
         shift_reg     <= '0;
         o_RX_DV       <= 1'b0;
         o_RX_Byte     <= '0;
         o_Framing_Err <= 1'b0;
      end else begin
         o_RX_DV       <= 1'b0;
         o_Framing_Err <= 1'b0;
         case (state)
            ST_IDLE: begin
               clk_cnt <= '0;
               bit_idx <= '0;
               if (!rx_s) begin
                  state <= ST_START;
               end
            end

            ST_START: begin
               if (clk_cnt == HALF_LAST) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            ST_DATA: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt            <= '0;
                  shift_reg[bit_idx] <= rx_s;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            ST_STOP: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  if (rx_s) begin
                     o_RX_Byte <= shift_reg;
                     o_RX_DV   <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     o_Framing_Err <= 1'b1;
                     state         <= ST_BREAK;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            ST_BREAK: begin
               clk_cnt <= '0;
               if (rx_s) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state   <= ST_IDLE;
               clk_cnt <= '0;
               bit_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled with 16 clocks per bit.
module tb_uart_rx_oversampled;
   import uart_pkg::*;

   localparam int unsigned CPB = 16;
   localparam int unsigned HALF = 8;
   localparam int unsigned LAT = 2 + HALF + 9 * CPB;

   typedef struct {
      int unsigned edge_n;
      logic [7:0]  data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;
   logic       o_Framing_Err;
   logic       o_Busy;

   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned dv_count = 0;
   int unsigned fe_count = 0;
   int unsigned last_dv_cyc = 0;
   logic [7:0]  exp_byte = 8'h00;
   ev_t         dvq[$];
   int unsigned feq[$];

   uart_rx_oversampled #(
      .CLOCK_RATE(16),
      .BAUD_RATE (1)
   ) dut (
      .i_Clock      (clk),
      .i_Rst_n      (rst_n),
      .i_RX_Serial  (rx),
      .o_RX_DV      (o_RX_DV),
      .o_RX_Byte    (o_RX_Byte),
      .o_Framing_Err(o_Framing_Err),
      .o_Busy       (o_Busy)
   );

   always #5 clk = ~clk;

   // Edge counter: after the Nth rising edge, cyc == N.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard compare on the falling edge, away from the active edge.
   always @(negedge clk) begin
      logic exp_dv;
      logic exp_fe;
      if (!rst_n) begin
         exp_byte = 8'h00;
         chk("rst_dv", 32'(o_RX_DV), 32'd0);
         chk("rst_fe", 32'(o_Framing_Err), 32'd0);
         chk("rst_busy", 32'(o_Busy), 32'd0);
         chk("rst_byte", 32'(o_RX_Byte), 32'd0);
      end else begin
         exp_dv = 1'b0;
         exp_fe = 1'b0;
         if (dvq.size() > 0 && dvq[0].edge_n == cyc) begin
            exp_dv   = 1'b1;
            exp_byte = dvq[0].data;
            void'(dvq.pop_front());
         end
         if (feq.size() > 0 && feq[0] == cyc) begin
            exp_fe = 1'b1;
            void'(feq.pop_front());
         end
         chk("dv", 32'(o_RX_DV), 32'(exp_dv));
         chk("fe", 32'(o_Framing_Err), 32'(exp_fe));
         chk("byte", 32'(o_RX_Byte), 32'(exp_byte));
         if (o_RX_DV) begin
            dv_count++;
            last_dv_cyc = cyc;
         end
         if (o_Framing_Err) fe_count++;
      end
   end

   // Drive the line for n bit-clock periods, starting just after a falling edge.
   task automatic hold(input logic v, input int unsigned n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int unsigned e0);
      e0 = cyc + 1;
      if (stop_bit) dvq.push_back('{e0 + LAT, b});
      else feq.push_back(e0 + LAT);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(b[i], CPB);
      hold(stop_bit, CPB);
   endtask

   initial begin
      int unsigned e0;
      logic [7:0] msg[4];
      msg[0] = 8'h4F; msg[1] = 8'h4E; msg[2] = 8'h31; msg[3] = LINE_TERM;

      repeat (4) @(negedge clk);
      // Deassert reset with the line idle; nothing may start.
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         chk("idle_busy", 32'(o_Busy), 32'd0);
         @(negedge clk);
      end

      // Single frame A5 and its absolute latency.
      send_frame(8'hA5, 1'b1, e0);
      hold(1'b1, 2 * CPB);
      chk("a5_latency", last_dv_cyc - e0, 32'd154);
      chk("a5_byte", 32'(o_RX_Byte), 32'hA5);
      chk("a5_dv_count", dv_count, 32'd1);
      chk("a5_fe_count", fe_count, 32'd0);

      // "ON1\n" back-to-back with one idle bit between frames.
      for (int i = 0; i < 4; i++) begin
         send_frame(msg[i], 1'b1, e0);
         hold(1'b1, CPB);
      end
      hold(1'b1, CPB);
      chk("on1_dv_count", dv_count, 32'd5);
      chk("on1_last_byte", 32'(o_RX_Byte), 32'h0A);

      // Five-clock glitch: rejected at the mid-start sample.
      e0 = cyc + 1;
      hold(1'b0, 5);
      chk("glitch_busy_mid", 32'(o_Busy), 32'd1);
      hold(1'b1, 7);
      chk("glitch_edge", cyc - e0, 32'd11);
      chk("glitch_busy_end", 32'(o_Busy), 32'd0);
      hold(1'b1, 2 * CPB);
      chk("glitch_dv_count", dv_count, 32'd5);
      chk("glitch_byte", 32'(o_RX_Byte), 32'h0A);

      // Framing error followed by a 40-bit break, then recovery.
      send_frame(8'h3C, 1'b0, e0);
      hold(1'b0, 40 * CPB);
      chk("break_busy", 32'(o_Busy), 32'd1);
      hold(1'b1, 2 * CPB);
      chk("break_fe_count", fe_count, 32'd1);
      chk("break_dv_count", dv_count, 32'd5);
      chk("break_byte", 32'(o_RX_Byte), 32'h0A);
      send_frame(8'h7B, 1'b1, e0);
      hold(1'b1, 2 * CPB);
      chk("after_break_byte", 32'(o_RX_Byte), 32'h7B);

      // Reset asserted asynchronously during bit 4 of a frame.
      e0 = cyc + 1;
      hold(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold(1'(8'hC3 >> i), CPB);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      #3 rst_n = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2 * CPB; i++) begin
         chk("post_rst_busy", 32'(o_Busy), 32'd0);
         @(negedge clk);
      end
      chk("post_rst_dv_count", dv_count, 32'd6);
      send_frame(8'h11, 1'b1, e0);
      hold(1'b1, 2 * CPB);
      chk("post_rst_byte", 32'(o_RX_Byte), 32'h11);
      chk("final_dv_count", dv_count, 32'd7);
      chk("final_fe_count", fe_count, 32'd1);
      chk("dvq_drained", dvq.size(), 32'd0);
      chk("feq_drained", feq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Run-time bound so the bench always ends.
   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- Upstream receive stage for the LED/sensor command path. Recovers 8N1 bytes from the ESP serial line (FPGA_RXD) and delivers each byte with a one-cycle valid strobe to the command parser.
- Adds an input synchroniser, start-bit glitch rejection, framing-error detection and break recovery.
- Standalone block; the parser consumes o_RX_DV/o_RX_Byte unchanged.

Parameters:
- CLOCK_RATE, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- CLKS_PER_BIT (derived localparam), CLOCK_RATE/BAUD_RATE with integer truncation (434 at defaults). Must be >= 4; elaboration fails otherwise.
- HALF_BIT (derived localparam), CLKS_PER_BIT/2 with truncation (217 at defaults).

Ports:
- i_Clock, input, 1, system clock. Single clock domain; all logic on its rising edge.
- i_Rst_n, input, 1, reset. Asynchronous and active-low.
- i_RX_Serial, input, 1, asynchronous serial line. Idle level is high.
- o_RX_DV, output, 1, one-cycle strobe: o_RX_Byte holds a new valid byte.
- o_RX_Byte, output, 8, last received byte, LSB received first. Held until the next o_RX_DV.
- o_Framing_Err, output, 1, one-cycle strobe: stop bit was sampled low.
- o_Busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, i_Rst_n=0):
  - o_RX_DV=0, o_RX_Byte=8'h00, o_Framing_Err=0, o_Busy=0.
  - State=IDLE, counters=0, shift register=0.
  - Both synchroniser flops preset to 1, so no false start bit is seen after reset.
- Synchroniser: two flops on i_RX_Serial. All decisions use the second flop (rx_s).
- IDLE: when rx_s==0, go to START with clk_cnt=0. Otherwise remain in IDLE.
- START: clk_cnt increments each cycle. At clk_cnt==HALF_BIT-1, sample rx_s:
  - rx_s==0: go to DATA with clk_cnt=0, bit_idx=0.
  - rx_s==1: glitch. Return to IDLE with no strobe.
- DATA: clk_cnt counts 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1:
  - shift register[bit_idx] <= rx_s, clk_cnt <= 0.
  - If bit_idx==7, go to STOP. Otherwise bit_idx increments.
- STOP: at clk_cnt==CLKS_PER_BIT-1, sample rx_s:
  - rx_s==1: o_RX_Byte <= shift register, o_RX_DV <= 1, go to IDLE.
  - rx_s==0: o_Framing_Err <= 1, o_RX_Byte is unchanged, go to BREAK.
- BREAK: remain until rx_s==1, then go to IDLE. A held-low line (break) produces exactly one o_Framing_Err and no further strobes.
- Strobes: o_RX_DV and o_Framing_Err are registered and last exactly one cycle. They are never high in the same cycle.
- Latency: let edge 0 be the first clock edge at which i_RX_Serial is sampled low.
  - Start sample occurs at edge 2+HALF_BIT.
  - o_RX_DV is high for the cycle following edge 2+HALF_BIT+9*CLKS_PER_BIT.
- Back-to-back frames: IDLE is re-entered at the mid-stop sample, so a start edge arriving half a bit later is accepted. Continuous streaming at nominal baud loses no bytes.
- Reset mid-frame: returns immediately to the reset state. The partial byte is discarded and no strobe is issued.
- Counter widths: clk_cnt uses $clog2(CLKS_PER_BIT) bits; bit_idx uses 3 bits. There is no wrap-around path other than explicit clears.

Decomposition:
- Shared package (uart_pkg), also reused by the TX side:
  - State encodings IDLE/START/DATA/STOP/BREAK as a 3-bit localparam set.
  - The CLKS_PER_BIT derivation function.
  - Constants 8'h0A (line terminator) and ">" (response start).
- Sub-module sync_2ff: parameterised reset value (1 here), asynchronous active-low reset. Reused for the other external inputs.

Test Plan:
Benches override CLOCK_RATE=16, BAUD_RATE=1, giving CLKS_PER_BIT=16 and HALF_BIT=8.
- Send 8'hA5 as an 8N1 frame (16 clocks per bit): o_RX_DV high for exactly one cycle after edge 154; o_RX_Byte=8'hA5; o_Framing_Err stays 0.
- Send "ON1",8'h0A back-to-back, one idle bit between frames: four strobes carrying 8'h4F, 8'h4E, 8'h31, 8'h0A, in order, none dropped.
- Drive the line low for 5 clocks, then high: no o_RX_DV; o_Busy returns to 0 by edge 11; o_RX_Byte keeps its previous value.
- Send 8'h3C with the stop bit driven low, then hold low for 40 bit times: exactly one o_Framing_Err pulse and no o_RX_DV. After the line goes high, a subsequent 8'h7B frame yields o_RX_Byte=8'h7B.
- Assert i_Rst_n=0 asynchronously during bit 4 of a frame, release it, then send 8'h11: all outputs are 0 during reset; no strobe for the aborted frame; the next strobe carries 8'h11.
- Line held at 1 throughout reset deassertion: o_Busy stays 0 and no strobe is issued.
